mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 87 ++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, mem_arbiter and the shared
// single-ported memory (1-cycle read latency).
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_func3;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        memory_wen;
    logic [31:0] memory_ra;
    logic [31:0] memory_wa;
    logic [31:0] memory_wd;
    logic [2:0]  memory_func3;
    logic [31:0] memory_rd;

    modport slave (
        input  if_req, if_addr, d_req, d_wen, d_addr, d_wdata, d_func3, memory_rd,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               memory_wen, memory_ra, memory_wa, memory_wd, memory_func3
    );

    modport master (
        output if_req, if_addr, d_req, d_wen, d_addr, d_wdata, d_func3, memory_rd,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               memory_wen, memory_ra, memory_wa, memory_wd, memory_func3
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port. Default: data priority with a
// fetch starvation limit; define ROUND_ROBIN_EN for round-robin arbitration instead.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_IF, RD_D, WR_D} state_t;

    state_t state;
    logic   pick_if;
    logic   gnt_if;
    logic   gnt_d;

`ifdef ROUND_ROBIN_EN
    typedef enum logic {LAST_IF, LAST_D} last_t;
    last_t last_win;

    always_comb pick_if = bus.if_req && (!bus.d_req || last_win == LAST_D);
`else
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
    logic [2:0] starve;

    always_comb pick_if = bus.if_req && (!bus.d_req || starve == LIMIT);
`endif

    // Grants are masked during reset so every output is quiet while reset is high.
    assign gnt_if = !reset && pick_if;
    assign gnt_d  = !reset && bus.d_req && !pick_if;

    assign bus.if_gnt     = gnt_if;
    assign bus.d_gnt      = gnt_d;
    assign bus.memory_wen = gnt_d && bus.d_wen;

    always_comb begin
        bus.memory_ra    = '0;
        bus.memory_wa    = '0;
        bus.memory_wd    = '0;
        bus.memory_func3 = '0;
        if (gnt_if) begin
            bus.memory_ra    = bus.if_addr;
            bus.memory_wa    = bus.if_addr;
            bus.memory_func3 = 3'b010;
        end else if (gnt_d) begin
            bus.memory_ra    = bus.d_addr;
            bus.memory_wa    = bus.d_addr;
            bus.memory_wd    = bus.d_wdata;
            bus.memory_func3 = bus.d_func3;
        end
    end

    assign bus.if_rvalid = (state == RD_IF);
    assign bus.d_rvalid  = (state == RD_D);
    assign bus.if_rdata  = (state == RD_IF) ? bus.memory_rd : '0;
    assign bus.d_rdata   = (state == RD_D)  ? bus.memory_rd : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
`ifdef ROUND_ROBIN_EN
            last_win <= LAST_D;
`else
            starve <= '0;
`endif
        end else begin
            if (gnt_if)
                state <= RD_IF;
            else if (gnt_d)
                state <= bus.d_wen ? WR_D : RD_D;
            else
                state <= IDLE;
`ifdef ROUND_ROBIN_EN
            if (gnt_if)
                last_win <= LAST_IF;
            else if (gnt_d)
                last_win <= LAST_D;
`else
            if (gnt_if || !bus.if_req)
                starve <= '0;
            else if (gnt_d && starve != LIMIT)
                starve <= starve + 3'd1;
`endif
        end
    end
endmodule
